mem_bus_arbiter: RTL

Two-to-one Wishbone arbiter that shares the single memory bus between the fetch stage (instruction port) and the memory stage (data port). It sits between the core's pipeline stages and the memory slave. It grants the bus with round-robin fairness and holds each grant for the full duration of the owner's `cyc`. A watchdog aborts transactions the slave never answers.

---
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-to-one Wishbone arbiter: fetch (instr) and memory-stage (data) masters share one slave bus.
// Round-robin grant held for the owner's whole cyc, with a watchdog that aborts unanswered cycles.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction requester
  input  logic        i_instr_cyc,
  input  logic        i_instr_stb,
  input  logic        i_instr_we,
  input  logic [3:0]  i_instr_sel,
  input  logic [31:0] i_instr_adr,
  input  logic [31:0] i_instr_dat_mosi,
  output logic [31:0] o_instr_dat_miso,
  output logic        o_instr_ack,
  output logic        o_instr_err,
  // data requester
  input  logic        i_data_cyc,
  input  logic        i_data_stb,
  input  logic        i_data_we,
  input  logic [3:0]  i_data_sel,
  input  logic [31:0] i_data_adr,
  input  logic [31:0] i_data_dat_mosi,
  output logic [31:0] o_data_dat_miso,
  output logic        o_data_ack,
  output logic        o_data_err,
  // shared memory bus
  output logic        o_mem_cyc,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat_mosi,
  input  logic [31:0] i_mem_dat_miso,
  input  logic        i_mem_ack,
  input  logic        i_mem_err,
  // status
  output logic [1:0]  o_grant_out,
  output logic        o_timeout_out
);

  // A zero timeout still needs a legal (unused) one-bit counter.
  localparam int unsigned CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  state_t        r_state, w_state_nxt;
  logic          r_last_grant;   // 1 = data port owned the bus last
  logic [CW-1:0] r_wdog, w_wdog_nxt;

  wb_req_t w_req_i, w_req_d, w_req_own;
  logic    w_granted, w_timeout;
  logic    w_resp_ack, w_resp_err;

  assign w_req_i = {i_instr_cyc, i_instr_stb, i_instr_we, i_instr_sel, i_instr_adr, i_instr_dat_mosi};
  assign w_req_d = {i_data_cyc,  i_data_stb,  i_data_we,  i_data_sel,  i_data_adr,  i_data_dat_mosi};

  // Arbitration: grant held while owner cyc is high, direct hand-off on release.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_instr_cyc && i_data_cyc) w_state_nxt = r_last_grant ? GRANT_I : GRANT_D;
        else if (i_instr_cyc)          w_state_nxt = GRANT_I;
        else if (i_data_cyc)           w_state_nxt = GRANT_D;
      end
      GRANT_I: if (!i_instr_cyc) w_state_nxt = i_data_cyc  ? GRANT_D : IDLE;
      GRANT_D: if (!i_data_cyc)  w_state_nxt = i_instr_cyc ? GRANT_I : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req_own = '0;
    case (r_state)
      GRANT_I: w_req_own = w_req_i;
      GRANT_D: w_req_own = w_req_d;
      default: w_req_own = '0;
    endcase
  end

  assign w_granted = (r_state != IDLE);
  assign w_timeout = WDOG_EN && w_granted && (r_wdog == TO_VAL);

  assign o_mem_cyc      = w_req_own.cyc & ~w_timeout;
  assign o_mem_stb      = w_req_own.stb & ~w_timeout;
  assign o_mem_we       = w_req_own.we;
  assign o_mem_sel      = w_req_own.sel;
  assign o_mem_adr      = w_req_own.adr;
  assign o_mem_dat_mosi = w_req_own.dat;

  // On the abort cycle a late slave ack is swallowed and err is reported instead.
  assign w_resp_ack = w_granted & i_mem_ack & ~w_timeout;
  assign w_resp_err = (w_granted & i_mem_err) | w_timeout;

  assign o_instr_ack      = (r_state == GRANT_I) & w_resp_ack;
  assign o_instr_err      = (r_state == GRANT_I) & w_resp_err;
  assign o_instr_dat_miso = (r_state == GRANT_I) ? i_mem_dat_miso : '0;
  assign o_data_ack       = (r_state == GRANT_D) & w_resp_ack;
  assign o_data_err       = (r_state == GRANT_D) & w_resp_err;
  assign o_data_dat_miso  = (r_state == GRANT_D) ? i_mem_dat_miso : '0;

  assign o_grant_out   = {r_state == GRANT_D, r_state == GRANT_I};
  assign o_timeout_out = w_timeout;

  always_comb begin
    w_wdog_nxt = r_wdog;
    if (!WDOG_EN || !w_granted || (w_state_nxt != r_state) ||
        i_mem_ack || i_mem_err || w_timeout)
      w_wdog_nxt = '0;
    else if (o_mem_stb && (r_wdog != CNT_MAX))
      w_wdog_nxt = r_wdog + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_wdog       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wdog  <= w_wdog_nxt;
      if (w_state_nxt != r_state) begin
        if (w_state_nxt == GRANT_I)      r_last_grant <= 1'b0;
        else if (w_state_nxt == GRANT_D) r_last_grant <= 1'b1;
      end
    end
  end

endmodule
